// File: rtl/hir_stream_pkg.sv
// Shared types for the BRAM stream reader: FSM state encoding and FIFO sizing.
package hir_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
  localparam int FIFO_DEPTH = 3;
endpackage

// File: rtl/hir_bram_stream_reader_if.sv
// BRAM read port plus output stream, bundled; master is the reader, slave is BRAM + consumer.
interface hir_bram_stream_reader_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int ELEMENT_WIDTH = 16
);
  logic                     mem_addr_en;
  logic [ADDR_WIDTH-1:0]    mem_addr_data;
  logic                     mem_rd_en;
  logic [ELEMENT_WIDTH-1:0] mem_rd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ELEMENT_WIDTH-1:0] out_data;
  logic                     out_last;

  modport master (
    output mem_addr_en, mem_addr_data, mem_rd_en,
    input  mem_rd_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr_en, mem_addr_data, mem_rd_en,
    output mem_rd_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/hir_rd_fifo.sv
// Small synchronous FIFO (non-power-of-two depth) with async active-low reset; dout shows the head.
module hir_rd_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/hir_bram_stream_reader.sv
// Sequential BRAM reader -> valid/ready stream. Optional macro HIR_STREAM_RD_STRIDE_EN adds a
// per-transfer address stride input; otherwise the address advances by 1.
module hir_bram_stream_reader
  import hir_stream_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int ELEMENT_WIDTH = 16,
  parameter int LEN_WIDTH     = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef HIR_STREAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  hir_bram_stream_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t              state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr, step;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   inflight, inflight_last;
  logic                   accept, issue, pop, last_hs;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic [ELEMENT_WIDTH:0] fifo_dout;

  assign accept = (state == IDLE) && start;
  // Occupancy counts the read still in the BRAM pipe, so a strobe never lacks a FIFO slot;
  // only registered state feeds this, keeping out_ready off the mem_* paths.
  assign issue  = (state == RUN) && (remaining != '0) &&
                  (({1'b0, fifo_count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH));
  assign pop     = bus.out_valid && bus.out_ready;
  assign last_hs = pop && fifo_dout[ELEMENT_WIDTH];

`ifdef HIR_STREAM_RD_STRIDE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        step <= '0;
    else if (accept) step <= stride;
  end
`else
  assign step = ADDR_WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_WIDTH'(1));
      if (accept) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr + step;
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length != '0) ? RUN : DONE;
      RUN:     if (issue && (remaining == LEN_WIDTH'(1))) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign bus.mem_addr_en   = issue;
  assign bus.mem_rd_en     = issue;
  assign bus.mem_addr_data = addr;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_data      = fifo_dout[ELEMENT_WIDTH-1:0];
  assign bus.out_last      = !fifo_empty && fifo_dout[ELEMENT_WIDTH];

  hir_rd_fifo #(.WIDTH(ELEMENT_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_last, bus.mem_rd_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_hir_bram_stream_reader.sv
// Directed bench for hir_bram_stream_reader: BRAM model, negedge monitor logs, linear checks.
module tb_hir_bram_stream_reader;
  localparam int AW = 10;
  localparam int EW = 16;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
`ifdef HIR_STREAM_RD_STRIDE_EN
  logic [AW-1:0] stride = AW'(1);
`endif

  hir_bram_stream_reader_if #(.ADDR_WIDTH(AW), .ELEMENT_WIDTH(EW)) bus ();

  hir_bram_stream_reader #(.ADDR_WIDTH(AW), .ELEMENT_WIDTH(EW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef HIR_STREAM_RD_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] memf(input logic [AW-1:0] a);
    return {6'h2b, a};
  endfunction

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= memf(bus.mem_addr_data);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            st_addr[$];
  int            st_cyc[$];
  logic [EW:0]   hs_data[$];
  int            hs_cyc[$];
  int            done_cnt = 0, done_cyc = 0, viol_occ = 0, viol_stab = 0, viol_rden = 0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_data = '0;
  int            vectors = 0, miscompares = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_rd_en !== bus.mem_addr_en) viol_rden++;
      if (bus.mem_addr_en) begin
        st_addr.push_back(int'(bus.mem_addr_data));
        st_cyc.push_back(cyc);
      end
      if (st_addr.size() - hs_data.size() > 3) viol_occ++;
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) viol_stab++;
      if (bus.out_valid && bus.out_ready) begin
        hs_data.push_back({bus.out_last, bus.out_data});
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    st_addr.delete(); st_cyc.delete(); hs_data.delete(); hs_cyc.delete();
    done_cnt = 0; viol_occ = 0; viol_stab = 0; viol_rden = 0;
  endtask

  task automatic do_start(input int b, input int l, output int t0);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(b); length = LW'(l);
    @(negedge clk);
    start = 1'b0; base_addr = AW'($urandom); length = LW'($urandom);
    t0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_run(input string tag, input int b, input int n, input int s);
    logic [AW-1:0] a;
    int            exp_hs;
    chk({tag, "_nstrobe"}, st_addr.size(), n);
    chk({tag, "_nhs"}, hs_data.size(), n);
    chk({tag, "_ndone"}, done_cnt, 1);
    chk({tag, "_rden"}, viol_rden, 0);
    for (int i = 0; i < n; i++) begin
      a      = AW'(b + i * s);
      exp_hs = int'({(i == n - 1), memf(a)});
      chk($sformatf("%s_addr%0d", tag, i), (i < st_addr.size()) ? st_addr[i] : -1, int'(a));
      chk($sformatf("%s_data%0d", tag, i), (i < hs_data.size()) ? int'(hs_data[i]) : -1, exp_hs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr_en", int'(bus.mem_addr_en), 0);
    chk("rst_addr", int'(bus.mem_addr_data), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_last", int'(bus.out_last), 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: base 5, len 4, consumer always ready
    clear_logs();
    do_start(5, 4, t0);
    chk("t1_busy", int'(busy), 1);
    wait_idle("t1", 40);
    chk_run("t1", 5, 4, 1);
    chk("t1_strobe0_cyc", (st_cyc.size() > 0) ? st_cyc[0] : -1, t0);
    chk("t1_strobe3_cyc", (st_cyc.size() > 3) ? st_cyc[3] : -1, t0 + 3);
    chk("t1_first_valid_cyc", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, t0 + 2);
    chk("t1_last_hs_cyc", (hs_cyc.size() > 3) ? hs_cyc[3] : -1, t0 + 5);
    chk("t1_done_cyc", done_cyc, t0 + 6);

    // 2: zero length
    clear_logs();
    do_start(9, 0, t0);
    wait_idle("t2", 10);
    chk("t2_nstrobe", st_addr.size(), 0);
    chk("t2_nhs", hs_data.size(), 0);
    chk("t2_ndone", done_cnt, 1);
    chk("t2_done_cyc", done_cyc, t0);

    // 3: address wrap
    clear_logs();
    do_start(1022, 4, t0);
    wait_idle("t3", 40);
    chk_run("t3", 1022, 4, 1);

    // 4: backpressure, toggling then a 5-cycle stall
    clear_logs();
    do_start(40, 8, t0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 bus.out_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #1 bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    wait_idle("t4", 60);
    chk_run("t4", 40, 8, 1);
    chk("t4_occupancy", viol_occ, 0);
    chk("t4_stall_stable", viol_stab, 0);

    // 5: reset mid-transfer after 3 handshakes, then a fresh transfer
    clear_logs();
    do_start(100, 8, t0);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_addr_en", int'(bus.mem_addr_en), 0);
    chk("t5_rd_en", int'(bus.mem_rd_en), 0);
    chk("t5_addr", int'(bus.mem_addr_data), 0);
    chk("t5_valid", int'(bus.out_valid), 0);
    chk("t5_data", int'(bus.out_data), 0);
    chk("t5_last", int'(bus.out_last), 0);
    @(negedge clk);
    chk("t5_hs_before_rst", hs_data.size(), 3);
    chk("t5_no_done", done_cnt, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    clear_logs();
    do_start(0, 2, t0);
    wait_idle("t5b", 30);
    chk_run("t5b", 0, 2, 1);

    // 6: start while busy is ignored
    clear_logs();
    do_start(200, 4, t0);
    start = 1'b1; base_addr = AW'(300); length = LW'(2);
    @(negedge clk); start = 1'b0;
    wait_idle("t6", 40);
    repeat (3) @(negedge clk);
    chk_run("t6", 200, 4, 1);

`ifdef HIR_STREAM_RD_STRIDE_EN
    // stride 3
    clear_logs();
    stride = AW'(3);
    do_start(0, 3, t0);
    stride = AW'(1);
    wait_idle("t7", 30);
    chk_run("t7", 0, 3, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
